// File: rtl/scramble_move_generator_if.sv
// Move handshake between the scramble generator and the board-update logic.
//   MoveValid  master -> slave  MoveCode holds a move to be applied
//   MoveCode   master -> slave  0 = up, 1 = down, 2 = left, 3 = right (inverse is code^1)
//   MoveReady  slave -> master  board-update logic takes the move this cycle
interface scramble_move_generator_if;
  logic       MoveValid;
  logic       MoveReady;
  logic [1:0] MoveCode;

  modport master (
    output MoveValid,
    output MoveCode,
    input  MoveReady
  );

  modport slave (
    input  MoveValid,
    input  MoveCode,
    output MoveReady
  );
endinterface

// File: rtl/scramble_move_generator.sv
// Scramble move generator: on a rising edge of RandomPlease, issues a burst of RandNum
// pseudo-random moves taken from a free-running 16-bit Galois LFSR.
// Optional feature macro: SCRAMBLE_NO_UNDO_EN -- never issue a move that immediately undoes
// the previous accepted move of the same burst.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   RandomPlease  scramble request level (rising edge starts a burst)
//   Abort         cancels a running burst without a Done pulse
//   moveIf        valid/ready move handshake (master side)
//   Busy          high from trigger until back in idle
//   Done          one-cycle pulse when a burst completes normally
//   MovesLeft     moves not yet accepted
module scramble_move_generator #(
  parameter int unsigned RandNum = 31,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        RandomPlease,
  input  logic                        Abort,
  scramble_move_generator_if.master   moveIf,
  output logic                        Busy,
  output logic                        Done,
  output logic [CNT_W-1:0]            MovesLeft
);

  localparam logic [15:0]      LfsrMask = 16'hB400;
  localparam logic [CNT_W-1:0] BurstLen = CNT_W'(RandNum);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr, lfsrNext;
  logic             RandomPlease_q;
  logic             trig;
  logic [1:0]       candidate;
  logic [1:0]       moveCode_q, moveCode_d;
  logic [CNT_W-1:0] movesLeft_q, movesLeft_d;

  assign trig = RandomPlease & ~RandomPlease_q;

  // The LFSR runs in every state so the scramble depends on when the player presses.
  always_comb begin
    if (lfsr == 16'h0) begin
      lfsrNext = SEED;
    end else if (lfsr[0]) begin
      lfsrNext = (lfsr >> 1) ^ LfsrMask;
    end else begin
      lfsrNext = lfsr >> 1;
    end
  end

`ifdef SCRAMBLE_NO_UNDO_EN
  logic [1:0] prevCode_q, prevCode_d;
  logic       prevValid_q, prevValid_d;
  logic       accept;

  assign accept = (state_q == StIssue) & moveIf.MoveReady & ~Abort;

  // prevCode_d already reflects a move accepted this cycle, so the replacement move loaded
  // alongside that accept is compared against it with no extra latency.
  always_comb begin
    prevCode_d  = prevCode_q;
    prevValid_d = prevValid_q;
    if ((state_q == StIdle) && trig) begin
      prevValid_d = 1'b0;
    end else if (accept) begin
      prevCode_d  = moveCode_q;
      prevValid_d = 1'b1;
    end
  end

  assign candidate = (prevValid_d && (lfsr[1:0] == (prevCode_d ^ 2'b01))) ?
                     (lfsr[1:0] ^ 2'b10) : lfsr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prevCode_q  <= 2'b00;
      prevValid_q <= 1'b0;
    end else begin
      prevCode_q  <= prevCode_d;
      prevValid_q <= prevValid_d;
    end
  end
`else
  assign candidate = lfsr[1:0];
`endif

  always_comb begin
    state_d     = state_q;
    moveCode_d  = moveCode_q;
    movesLeft_d = movesLeft_q;
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          if (RandNum == 0) begin
            state_d = StDone;
          end else begin
            state_d     = StIssue;
            movesLeft_d = BurstLen;
            moveCode_d  = candidate;
          end
        end
      end
      StIssue: begin
        // Abort wins over a simultaneous handshake: that move is not counted.
        if (Abort) begin
          state_d     = StIdle;
          movesLeft_d = '0;
        end else if (moveIf.MoveReady) begin
          if (movesLeft_q != '0) begin
            movesLeft_d = movesLeft_q - CNT_W'(1);
          end
          if (movesLeft_q <= CNT_W'(1)) begin
            state_d = StDone;
          end else begin
            moveCode_d = candidate;
          end
        end
      end
      StDone: begin
        state_d     = StIdle;
        movesLeft_d = '0;
      end
      default: begin
        state_d     = StIdle;
        movesLeft_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      lfsr           <= SEED;
      RandomPlease_q <= 1'b0;
      moveCode_q     <= 2'b00;
      movesLeft_q    <= '0;
    end else begin
      state_q        <= state_d;
      lfsr           <= lfsrNext;
      RandomPlease_q <= RandomPlease;
      moveCode_q     <= moveCode_d;
      movesLeft_q    <= movesLeft_d;
    end
  end

  assign moveIf.MoveValid = (state_q == StIssue);
  assign moveIf.MoveCode  = moveCode_q;
  assign Busy             = (state_q != StIdle);
  assign Done             = (state_q == StDone);
  assign MovesLeft        = movesLeft_q;

endmodule
